// File: rtl/xbar_slave_write_router.sv
// xbar_slave_write_router: steers W beats of the master that won each AW (in grant order) to the slave W path.
// Ports:
//   aclk_i, aresetn_i          clock, asynchronous active-low reset
//   aw_grant_valid_i/master_i/len_i, aw_grant_ready_o
//                              AW forwarded to this slave (push into the order queue)
//   m_wvalid_i/wdata_i/wstrb_i/wlast_i, m_wready_o
//                              per-master W FIFO fronts, packed by master index, and their pop strobes
//   s_wvalid_o/wdata_o/wstrb_o/wlast_o, s_wready_i
//                              beat toward the slave W FIFO
//   pending_count_o            order-queue occupancy
//   len_error_o, err_clr_i     sticky WLAST/AWLEN mismatch flag and its synchronous clear
module xbar_slave_write_router #(
    parameter int MASTERS     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = 4,
    parameter int LEN_WIDTH   = 4,
    parameter int OUTSTANDING = 4,
    parameter int CHECK_LEN   = 1
) (
    input  logic                               aclk_i,
    input  logic                               aresetn_i,
    input  logic                               aw_grant_valid_i,
    input  logic [$clog2(MASTERS)-1:0]         aw_grant_master_i,
    input  logic [LEN_WIDTH-1:0]               aw_grant_len_i,
    output logic                               aw_grant_ready_o,
    input  logic [MASTERS-1:0]                 m_wvalid_i,
    input  logic [MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
    input  logic [MASTERS*STRB_WIDTH-1:0]      m_wstrb_i,
    input  logic [MASTERS-1:0]                 m_wlast_i,
    output logic [MASTERS-1:0]                 m_wready_o,
    output logic                               s_wvalid_o,
    output logic [DATA_WIDTH-1:0]              s_wdata_o,
    output logic [STRB_WIDTH-1:0]              s_wstrb_o,
    output logic                               s_wlast_o,
    input  logic                               s_wready_i,
    output logic [$clog2(OUTSTANDING+1)-1:0]   pending_count_o,
    output logic                               len_error_o,
    input  logic                               err_clr_i
);
    localparam int MW = $clog2(MASTERS);
    localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    logic [MW-1:0]        master_q [OUTSTANDING];
    logic [LEN_WIDTH-1:0] len_q    [OUTSTANDING];
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 len_error_q, len_error_d;
    logic                 empty, full, push, accept, last_beat, burst_end, len_mismatch;
    logic [MW-1:0]        h;
    logic [LEN_WIDTH-1:0] h_len;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty            = count_q == '0;
        full             = count_q == CW'(OUTSTANDING);
        h                = master_q[head_q];
        h_len            = len_q[head_q];
        // Readiness looks only at registered occupancy, so a pop cannot make room for a push in the same cycle.
        push             = aw_grant_valid_i & ~full;
        aw_grant_ready_o = ~full;
        s_wvalid_o       = ~empty & m_wvalid_i[h];
        s_wdata_o        = m_wdata_i[int'(h)*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb_o        = m_wstrb_i[int'(h)*STRB_WIDTH +: STRB_WIDTH];
        last_beat        = beat_cnt_q == h_len;
        accept           = s_wvalid_o & s_wready_i;
        s_wlast_o        = ~empty & (CHECK_LEN != 0 ? last_beat : m_wlast_i[h]);
        burst_end        = accept & (CHECK_LEN != 0 ? last_beat : m_wlast_i[h]);
        len_mismatch     = CHECK_LEN != 0 && accept && (m_wlast_i[h] != last_beat);
        m_wready_o       = '0;
        m_wready_o[h]    = accept;
        head_d           = burst_end ? nxt(head_q) : head_q;
        tail_d           = push ? nxt(tail_q) : tail_q;
        count_d          = count_q + CW'(push) - CW'(burst_end);
        beat_cnt_d       = burst_end ? '0 : accept ? beat_cnt_q + 1'b1 : beat_cnt_q;
        // A new mismatch wins over a clear arriving in the same cycle.
        len_error_d      = len_mismatch | (len_error_q & ~err_clr_i);
        pending_count_o  = count_q;
        len_error_o      = len_error_q;
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            beat_cnt_q  <= '0;
            len_error_q <= 1'b0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                master_q[i] <= '0;
                len_q[i]    <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            beat_cnt_q  <= beat_cnt_d;
            len_error_q <= len_error_d;
            if (push) begin
                master_q[tail_q] <= aw_grant_master_i;
                len_q[tail_q]    <= aw_grant_len_i;
            end
        end
    end
endmodule

// File: tb/tb_xbar_slave_write_router.sv
// tb_xbar_slave_write_router: randomized bench for xbar_slave_write_router against a queue-based model.
module tb_xbar_slave_write_router;
    localparam int M = 2, DW = 32, SW = 4, LW = 4, OS = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic awv, awr, swv, swl, swr, lerr, eclr;
    logic [0:0] awm;
    logic [LW-1:0] awl;
    logic [M-1:0] mwv, mwl, mwr;
    logic [M*DW-1:0] mwd;
    logic [M*SW-1:0] mws;
    logic [DW-1:0] swd;
    logic [SW-1:0] sws;
    logic [2:0] pc;

    xbar_slave_write_router #(.MASTERS(M), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LEN_WIDTH(LW),
                              .OUTSTANDING(OS), .CHECK_LEN(1)) dut (
        .aclk_i(clk), .aresetn_i(rst_n),
        .aw_grant_valid_i(awv), .aw_grant_master_i(awm), .aw_grant_len_i(awl), .aw_grant_ready_o(awr),
        .m_wvalid_i(mwv), .m_wdata_i(mwd), .m_wstrb_i(mws), .m_wlast_i(mwl), .m_wready_o(mwr),
        .s_wvalid_o(swv), .s_wdata_o(swd), .s_wstrb_o(sws), .s_wlast_o(swl), .s_wready_i(swr),
        .pending_count_o(pc), .len_error_o(lerr), .err_clr_i(eclr)
    );

    typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; logic l; } beat_t;
    typedef struct { int m; int len; } aw_t;
    beat_t mq0[$], mq1[$];
    aw_t   oq[$];
    int    cnt = 0, force_bad = -1;
    bit    err_m = 0;
    bit    en [M];
    int    errors = 0, checks = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic beat_t front(input int m);
        beat_t b;
        b = '{d: '0, s: '0, l: 1'b0};
        if (m == 0 && mq0.size() > 0) b = mq0[0];
        if (m == 1 && mq1.size() > 0) b = mq1[0];
        return b;
    endfunction

    function automatic int qsize(input int m);
        return m == 0 ? mq0.size() : mq1.size();
    endfunction

    task automatic drive_w();
        for (int i = 0; i < M; i++) begin
            beat_t b;
            b = front(i);
            mwv[i] = en[i] && qsize(i) > 0;
            mwd[i*DW +: DW] = b.d;
            mws[i*SW +: SW] = b.s;
            mwl[i] = b.l;
        end
    endtask

    // Expected outputs from the model: head of grant order selects the master, beat index decides WLAST.
    task automatic compare();
        int h;
        beat_t b;
        logic [M-1:0] emr;
        emr = '0;
        chk("aw_ready", awr, oq.size() < OS);
        chk("pending", pc, oq.size());
        chk("len_error", lerr, err_m);
        if (oq.size() == 0) chk("s_wvalid_idle", swv, 0);
        else begin
            h = oq[0].m;
            chk("s_wvalid", swv, mwv[h]);
            if (mwv[h]) begin
                b = front(h);
                chk("s_wdata", swd, b.d);
                chk("s_wstrb", sws, b.s);
                chk("s_wlast", swl, cnt == oq[0].len);
                if (swr) emr[h] = 1'b1;
            end
        end
        chk("m_wready", mwr, emr);
    endtask

    task automatic step();
        bit full0, acc, le;
        int h, bad;
        full0 = oq.size() >= OS;
        acc = 0; le = 0; h = 0;
        if (oq.size() > 0) begin
            h = oq[0].m;
            acc = mwv[h] && swr;
            le = cnt == oq[0].len;
        end
        err_m = (acc && mwl[h] != le) ? 1'b1 : (eclr ? 1'b0 : err_m);
        if (acc) begin
            if (h == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
            if (le) begin
                void'(oq.pop_front());
                cnt = 0;
            end else cnt++;
        end
        if (awv && !full0) begin
            oq.push_back('{int'(awm), int'(awl)});
            bad = force_bad >= 0 ? force_bad : ($urandom_range(0, 19) == 0 ? int'($urandom_range(0, int'(awl))) : -1);
            force_bad = -1;
            for (int k = 0; k <= int'(awl); k++) begin
                beat_t b;
                b.d = $urandom;
                b.s = SW'($urandom);
                b.l = (k == int'(awl)) ^ (k == bad);
                if (awm == 0) mq0.push_back(b); else mq1.push_back(b);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        step();
        #1;
        drive_w();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_aw_ready"}, awr, 1);
        chk({tag, "_pending"}, pc, 0);
        chk({tag, "_s_wvalid"}, swv, 0);
        chk({tag, "_m_wready"}, mwr, 0);
        chk({tag, "_len_error"}, lerr, 0);
    endtask

    initial begin
        awv = 0; awm = 0; awl = 0; swr = 0; eclr = 0;
        for (int i = 0; i < M; i++) en[i] = 1;
        drive_w();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1;
        // AW m1 len=3 with four beats: forwarded on the four following cycles, WLAST on the fourth.
        awv = 1; awm = 1; awl = 3; swr = 1;
        cycle();
        awv = 0;
        drive_w();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_pending", pc, 1);
            chk("t1_valid", swv, 1);
            chk("t1_last", swl, k == 3);
            chk("t1_mready", mwr, 2'b10);
            cycle();
        end
        #1;
        chk("t1_done_pending", pc, 0);
        chk("t1_done_valid", swv, 0);
        // Fill the order queue with no W available; the fifth grant must be dropped.
        for (int i = 0; i < M; i++) en[i] = 0;
        awv = 1; awl = 1;
        for (int k = 0; k < 5; k++) begin
            awm = 1'(k);
            cycle();
        end
        awv = 0;
        #1;
        chk("t3_pending_full", pc, 4);
        chk("t3_ready_full", awr, 0);
        for (int i = 0; i < M; i++) en[i] = 1;
        drive_w();
        repeat (12) cycle();
        #1;
        chk("t3_drained", pc, 0);
        // AWLEN=2 with the master's WLAST on beat index 1: flag sets and sticks until cleared.
        awv = 1; awm = 0; awl = 2; force_bad = 1;
        cycle();
        awv = 0;
        repeat (5) cycle();
        #1;
        chk("t4_len_error", lerr, 1);
        eclr = 1;
        cycle();
        eclr = 0;
        #1;
        chk("t4_cleared", lerr, 0);
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                awv = 0;
                rst_n = 0;
                #1;
                reset_checks("midrst");
                oq.delete(); mq0.delete(); mq1.delete();
                cnt = 0; err_m = 0;
                drive_w();
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1;
            end
            awv = $urandom_range(0, 2) == 0;
            awm = 1'($urandom);
            awl = $urandom_range(0, 15) == 0 ? LW'(15) : LW'($urandom_range(0, 3));
            swr = $urandom_range(0, 3) != 0;
            eclr = $urandom_range(0, 19) == 0;
            for (int i = 0; i < M; i++) en[i] = $urandom_range(0, 3) != 0;
            drive_w();
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
